// File: rtl/pixel_coord_roi_pkg.sv
// rtl/pixel_coord_roi_pkg.sv - shared FSM state encoding and coordinate limit helper
package pixel_coord_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        LINE     = 2'd1,
        HBLANK   = 2'd2
    } fsm_state_e;

    function automatic int coord_max(input int coord_width);
        return (1 << coord_width) - 1;
    endfunction

endpackage

// File: rtl/pixel_coord_roi_if.sv
// rtl/pixel_coord_roi_if.sv - camera input stream and ROI output stream interfaces
interface cam_stream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   vsync;
    logic                   hsync;
    logic                   de;
    logic                   field;
    logic [PIXEL_WIDTH-1:0] data_l;
    logic [PIXEL_WIDTH-1:0] data_r;

    modport master (output vsync, hsync, de, field, data_l, data_r);
    modport slave  (input  vsync, hsync, de, field, data_l, data_r);
endinterface

interface roi_stream_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COORD_WIDTH = 11
);
    logic                   de;
    logic                   field;
    logic                   sof;
    logic                   eof;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [PIXEL_WIDTH-1:0] data_l;
    logic [PIXEL_WIDTH-1:0] data_r;

    modport master (output de, field, sof, eof, x, y, data_l, data_r);
    modport slave  (input  de, field, sof, eof, x, y, data_l, data_r);
endinterface

// File: rtl/pixel_coord_roi_sync_edge_det.sv
// rtl/pixel_coord_roi_sync_edge_det.sv - rise/fall pulses of a 1-bit input against its registered copy
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    // Pulses are valid in the same cycle as the new level so the caller keeps 1-cycle latency.
    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/pixel_coord_roi.sv
// rtl/pixel_coord_roi.sv - X/Y coordinate generation and ROI gating; PIXEL_COORD_MEASURE_EN adds frame size measurement
module pixel_coord_roi
    import pixel_coord_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    cam_stream_if.slave            cam,
    input  logic [COORD_WIDTH-1:0] roi_x0,
    input  logic [COORD_WIDTH-1:0] roi_x1,
    input  logic [COORD_WIDTH-1:0] roi_y0,
    input  logic [COORD_WIDTH-1:0] roi_y1,
    roi_stream_if.master           roi,
    output logic                   ovf,
    output logic [15:0]            frame_cnt,
    output logic [COORD_WIDTH-1:0] meas_w,
    output logic [COORD_WIDTH-1:0] meas_h,
    output logic                   meas_valid
);

    localparam logic [1:0] S_WAIT_SOF = WAIT_SOF;
    localparam logic [1:0] S_LINE     = LINE;
    localparam logic [1:0] S_HBLANK   = HBLANK;
    localparam logic [COORD_WIDTH-1:0] COORD_MAX = COORD_WIDTH'(coord_max(COORD_WIDTH));

    logic vs_rise, vs_fall, de_rise, de_fall;
    logic unused_hsync;

    assign unused_hsync = cam.hsync;

    // Sync reset value 1 on vsync: a frame already in progress at reset is not taken as a new start.
    sync_edge_det #(.RESET_VAL(1'b1)) u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cam.vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_de_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cam.de),
        .rise (de_rise),
        .fall (de_fall)
    );

    logic [1:0]             state, state_nxt;
    logic [COORD_WIDTH-1:0] x, y;
    logic [COORD_WIDTH-1:0] sx0, sx1, sy0, sy1;
    logic [COORD_WIDTH-1:0] cur_x, cur_y, ex0, ex1, ey0, ey1;
    logic                   in_frame, pix, line_end, in_roi, x_sat, y_sat;

    always_comb begin
        state_nxt = state;
        if (vs_rise) begin
            state_nxt = S_LINE;
        end else if (vs_fall) begin
            state_nxt = S_WAIT_SOF;
        end else begin
            case (state)
                S_LINE:   if (de_fall) state_nxt = S_HBLANK;
                S_HBLANK: if (de_rise) state_nxt = S_LINE;
                default:  state_nxt = state;
            endcase
        end
    end

    // The pixel on the vsync rise cycle already belongs to the new frame and its ROI.
    always_comb begin
        cur_x    = vs_rise ? '0     : x;
        cur_y    = vs_rise ? '0     : y;
        ex0      = vs_rise ? roi_x0 : sx0;
        ex1      = vs_rise ? roi_x1 : sx1;
        ey0      = vs_rise ? roi_y0 : sy0;
        ey1      = vs_rise ? roi_y1 : sy1;
        in_frame = vs_rise | ((state != S_WAIT_SOF) & cam.vsync);
        pix      = cam.de & in_frame;
        line_end = de_fall & in_frame & ~vs_rise;
        in_roi   = pix & (cur_x >= ex0) & (cur_x <= ex1) & (cur_y >= ey0) & (cur_y <= ey1);
        x_sat    = pix & (cur_x == COORD_MAX);
        y_sat    = line_end & (y == COORD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_SOF;
            x         <= '0;
            y         <= '0;
            sx0       <= '0;
            sx1       <= '0;
            sy0       <= '0;
            sy1       <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (vs_rise) begin
                sx0       <= roi_x0;
                sx1       <= roi_x1;
                sy0       <= roi_y0;
                sy1       <= roi_y1;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (pix) begin
                x <= x_sat ? cur_x : cur_x + 1'b1;
            end else if (vs_rise || line_end) begin
                x <= '0;
            end
            if (vs_rise) begin
                y <= '0;
            end else if (line_end && !y_sat) begin
                y <= y + 1'b1;
            end
            ovf <= (ovf & ~vs_rise) | x_sat | y_sat;
        end
    end

    // Output pipeline: coordinates and data only advance on ROI pixels, otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            roi.de     <= 1'b0;
            roi.sof    <= 1'b0;
            roi.eof    <= 1'b0;
            roi.field  <= 1'b0;
            roi.x      <= '0;
            roi.y      <= '0;
            roi.data_l <= '0;
            roi.data_r <= '0;
        end else begin
            roi.de  <= in_roi;
            roi.sof <= in_roi & (cur_x == ex0) & (cur_y == ey0);
            roi.eof <= in_roi & (cur_x == ex1) & (cur_y == ey1);
            if (vs_rise) begin
                roi.field <= cam.field;
            end
            if (in_roi) begin
                roi.x      <= cur_x;
                roi.y      <= cur_y;
                roi.data_l <= cam.data_l;
                roi.data_r <= cam.data_r;
            end
        end
    end

`ifdef PIXEL_COORD_MEASURE_EN
    logic [COORD_WIDTH-1:0] line_len, max_len, line_cnt;
    logic [COORD_WIDTH-1:0] max_done, cnt_done;
    logic                   meas_line_end;

    // A line closing on the same cycle as the vsync edge still counts toward the finished frame.
    always_comb begin
        meas_line_end = de_fall & (state != S_WAIT_SOF);
        max_done      = max_len;
        cnt_done      = line_cnt;
        if (meas_line_end) begin
            max_done = (line_len > max_len) ? line_len : max_len;
            cnt_done = (line_cnt == COORD_MAX) ? line_cnt : line_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_len   <= '0;
            max_len    <= '0;
            line_cnt   <= '0;
            meas_w     <= '0;
            meas_h     <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (vs_rise || vs_fall) begin
                if (cnt_done != '0) begin
                    meas_w     <= max_done;
                    meas_h     <= cnt_done;
                    meas_valid <= 1'b1;
                end
                max_len  <= '0;
                line_cnt <= '0;
                line_len <= (vs_rise && pix) ? COORD_WIDTH'(1) : '0;
            end else begin
                max_len  <= max_done;
                line_cnt <= cnt_done;
                if (pix) begin
                    line_len <= (line_len == COORD_MAX) ? line_len : line_len + 1'b1;
                end else if (meas_line_end) begin
                    line_len <= '0;
                end
            end
        end
    end
`else
    assign meas_w     = '0;
    assign meas_h     = '0;
    assign meas_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_coord_roi.sv
// tb/tb_pixel_coord_roi.sv - directed table-driven bench for pixel_coord_roi
module tb_pixel_coord_roi;

    localparam int PW  = 8;
    localparam int CW  = 11;
    localparam int CWS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_stream_if #(.PIXEL_WIDTH(PW)) cam ();
    roi_stream_if #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CW))  roi ();
    roi_stream_if #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CWS)) roi_s ();

    logic [CW-1:0]  roi_x0, roi_x1, roi_y0, roi_y1;
    logic           ovf, ovf_s, meas_valid, meas_valid_s;
    logic [15:0]    frame_cnt, frame_cnt_s;
    logic [CW-1:0]  meas_w, meas_h;
    logic [CWS-1:0] meas_w_s, meas_h_s;

    pixel_coord_roi #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cam        (cam),
        .roi_x0     (roi_x0),
        .roi_x1     (roi_x1),
        .roi_y0     (roi_y0),
        .roi_y1     (roi_y1),
        .roi        (roi),
        .ovf        (ovf),
        .frame_cnt  (frame_cnt),
        .meas_w     (meas_w),
        .meas_h     (meas_h),
        .meas_valid (meas_valid)
    );

    pixel_coord_roi #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CWS)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .cam        (cam),
        .roi_x0     (3'd0),
        .roi_x1     (3'd7),
        .roi_y0     (3'd0),
        .roi_y1     (3'd7),
        .roi        (roi_s),
        .ovf        (ovf_s),
        .frame_cnt  (frame_cnt_s),
        .meas_w     (meas_w_s),
        .meas_h     (meas_h_s),
        .meas_valid (meas_valid_s)
    );

    typedef struct {
        int w, h, x0, x1, y0, y1;
        bit rise_de, mid;
        int e_de, e_sof, e_eof, e_both, e_sx, e_sy, e_ex, e_ey;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_frames = 0;
    int mon_de, mon_sof, mon_eof, mon_both, mon_bad, mon_meas;
    int sof_x, sof_y, eof_x, eof_y, first_x, first_y, last_mw, last_mh;
    bit got_first;
    logic field_drv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void mon_clear();
        mon_de = 0; mon_sof = 0; mon_eof = 0; mon_both = 0; mon_bad = 0; mon_meas = 0;
        sof_x = -1; sof_y = -1; eof_x = -1; eof_y = -1;
        first_x = -1; first_y = -1; got_first = 1'b0;
        last_mw = 0; last_mh = 0;
    endfunction

    task automatic step(input logic vs, input logic de, input int px, input int py);
        logic [PW-1:0] dl;
        dl = PW'(py * 16 + px);
        cam.vsync  = vs;
        cam.hsync  = de;
        cam.de     = de;
        cam.field  = field_drv;
        cam.data_l = dl;
        cam.data_r = ~dl;
        @(posedge clk);
        #1;
        if (roi.de) begin
            mon_de++;
            if (!got_first) begin
                first_x = int'(roi.x);
                first_y = int'(roi.y);
                got_first = 1'b1;
            end
            if (!(de && roi.x == CW'(px) && roi.y == CW'(py) && roi.data_l == dl && roi.data_r == ~dl))
                mon_bad++;
        end
        if (roi.sof) begin mon_sof++; sof_x = int'(roi.x); sof_y = int'(roi.y); end
        if (roi.eof) begin mon_eof++; eof_x = int'(roi.x); eof_y = int'(roi.y); end
        if (roi.sof && roi.eof) mon_both++;
        if ((roi.sof || roi.eof) && !roi.de) mon_bad++;
        if (meas_valid) begin mon_meas++; last_mw = int'(meas_w); last_mh = int'(meas_h); end
    endtask

    task automatic run_frame(input int w, h, x0, x1, y0, y1, input bit rise_de, mid, fld);
        mon_clear();
        roi_x0 = CW'(x0); roi_x1 = CW'(x1); roi_y0 = CW'(y0); roi_y1 = CW'(y1);
        field_drv = fld;
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        exp_frames++;
        if (!rise_de) step(1'b1, 1'b0, 0, 0);
        for (int ly = 0; ly < h; ly++) begin
            for (int lx = 0; lx < w; lx++) begin
                step(1'b1, 1'b1, lx, ly);
                field_drv = ~fld;
            end
            step(1'b1, 1'b0, 0, 0);
            step(1'b1, 1'b0, 0, 0);
            if (mid && ly == 0) begin
                roi_x0 = '0; roi_x1 = CW'(7); roi_y0 = '0; roi_y1 = CW'(3);
            end
        end
        step(1'b0, 1'b0, 0, 0);
    endtask

    function automatic logic outs_nonzero();
        return |{roi.de, roi.sof, roi.eof, roi.field, roi.x, roi.y, roi.data_l, roi.data_r,
                 ovf, frame_cnt, meas_w, meas_h, meas_valid,
                 roi_s.de, roi_s.x, roi_s.y, ovf_s, frame_cnt_s};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        int   sat_bad;
        vecs[0] = '{8, 4, 2, 5, 1, 2, 1'b0, 1'b0,  8, 1, 1, 0,  2,  1,  5,  2};
        vecs[1] = '{8, 4, 6, 3, 0, 3, 1'b0, 1'b0,  0, 0, 0, 0, -1, -1, -1, -1};
        vecs[2] = '{8, 4, 0, 0, 0, 0, 1'b1, 1'b0,  1, 1, 1, 1,  0,  0,  0,  0};
        vecs[3] = '{8, 4, 0, 7, 0, 3, 1'b0, 1'b0, 32, 1, 1, 0,  0,  0,  7,  3};
        vecs[4] = '{8, 4, 6, 9, 2, 5, 1'b0, 1'b0,  4, 1, 0, 0,  6,  2, -1, -1};
        vecs[5] = '{8, 4, 1, 2, 1, 2, 1'b0, 1'b1,  4, 1, 1, 0,  1,  1,  2,  2};
        vecs[6] = '{5, 3, 4, 4, 2, 2, 1'b1, 1'b0,  1, 1, 1, 1,  4,  2,  4,  2};

        rst = 1'b1;
        field_drv = 1'b0;
        cam.vsync = 1'b0; cam.hsync = 1'b0; cam.de = 1'b0; cam.field = 1'b0;
        cam.data_l = '0; cam.data_r = '0;
        roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", outs_nonzero(), 1'b0);
        rst = 1'b0;

        // Mid-line reset: a frame is running, reset lands in the middle of line 1.
        roi_x0 = '0; roi_x1 = CW'(7); roi_y0 = '0; roi_y1 = CW'(3);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        for (int lx = 0; lx < 8; lx++) step(1'b1, 1'b1, lx, 0);
        step(1'b1, 1'b0, 0, 0);
        for (int lx = 0; lx < 4; lx++) step(1'b1, 1'b1, lx, 1);
        rst = 1'b1;
        for (int lx = 4; lx < 7; lx++) step(1'b1, 1'b1, lx, 1);
        check("midline_reset_outputs_zero", outs_nonzero(), 1'b0);
        rst = 1'b0;
        mon_clear();
        for (int lx = 0; lx < 4; lx++) step(1'b1, 1'b1, lx, 2);
        check("post_reset_ignored_de", mon_de, 0);
        check("post_reset_frame_cnt", frame_cnt, 0);

        exp_frames = 0;
        run_frame(8, 4, 0, 7, 0, 3, 1'b0, 1'b0, 1'b1);
        check("first_frame_x0", first_x, 0);
        check("first_frame_y0", first_y, 0);
        check("first_frame_de_count", mon_de, 32);
        check("first_frame_cnt", frame_cnt, 1);
        check("first_frame_bad", mon_bad, 0);
        check("first_frame_field", roi.field, 1'b1);
`ifdef PIXEL_COORD_MEASURE_EN
        check("meas_pulses_first", mon_meas, 1);
        check("meas_w_first", last_mw, 8);
        check("meas_h_first", last_mh, 4);
`else
        check("meas_pulses_first", mon_meas, 0);
        check("meas_w_zero", meas_w, 0);
        check("meas_h_zero", meas_h, 0);
`endif

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].w, vecs[i].h, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                      vecs[i].rise_de, vecs[i].mid, i[0]);
            check($sformatf("v%0d_de_count", i), mon_de, vecs[i].e_de);
            check($sformatf("v%0d_sof_count", i), mon_sof, vecs[i].e_sof);
            check($sformatf("v%0d_eof_count", i), mon_eof, vecs[i].e_eof);
            check($sformatf("v%0d_sof_eof_same", i), mon_both, vecs[i].e_both);
            check($sformatf("v%0d_sof_x", i), sof_x, vecs[i].e_sx);
            check($sformatf("v%0d_sof_y", i), sof_y, vecs[i].e_sy);
            check($sformatf("v%0d_eof_x", i), eof_x, vecs[i].e_ex);
            check($sformatf("v%0d_eof_y", i), eof_y, vecs[i].e_ey);
            check($sformatf("v%0d_pixel_align", i), mon_bad, 0);
            check($sformatf("v%0d_frame_cnt", i), frame_cnt, exp_frames);
            check($sformatf("v%0d_frame_cnt_s", i), frame_cnt_s, exp_frames);
            check($sformatf("v%0d_ovf", i), ovf, 1'b0);
            check($sformatf("v%0d_field", i), roi.field, i[0]);
`ifdef PIXEL_COORD_MEASURE_EN
            check($sformatf("v%0d_meas_pulses", i), mon_meas, 1);
            check($sformatf("v%0d_meas_w", i), last_mw, vecs[i].w);
            check($sformatf("v%0d_meas_h", i), last_mh, vecs[i].h);
`else
            check($sformatf("v%0d_meas_pulses", i), mon_meas, 0);
`endif
        end

        // Saturation on the 3-bit instance: a 10-pixel line clamps x at 7.
        mon_clear();
        roi_x0 = '0; roi_x1 = '1; roi_y0 = '0; roi_y1 = '1;
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        exp_frames++;
        step(1'b1, 1'b0, 0, 0);
        check("sat_ovf_clear_on_sof", ovf_s, 1'b0);
        sat_bad = 0;
        for (int lx = 0; lx < 10; lx++) begin
            step(1'b1, 1'b1, lx, 0);
            if (!(roi_s.de && roi_s.x == CWS'(lx < 7 ? lx : 7))) sat_bad++;
            if (lx == 6) check("sat_ovf_before_limit", ovf_s, 1'b0);
            if (lx == 7) check("sat_ovf_at_limit", ovf_s, 1'b1);
        end
        check("sat_x_clamped_trace", sat_bad, 0);
        check("sat_x_final", roi_s.x, 3'd7);
        check("sat_wide_x_final", roi.x, 9);
        check("sat_wide_no_ovf", ovf, 1'b0);
        check("sat_wide_align", mon_bad, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        check("sat_ovf_sticky_after_frame", ovf_s, 1'b1);

        step(1'b0, 1'b0, 0, 0);
        exp_frames++;
        step(1'b1, 1'b0, 0, 0);
        check("sat_ovf_clear_next_frame", ovf_s, 1'b0);
        for (int lx = 0; lx < 4; lx++) step(1'b1, 1'b1, lx, 0);
        step(1'b1, 1'b0, 0, 0);
        check("narrow_ovf_stays_clear", ovf_s, 1'b0);
        check("narrow_x_final", roi_s.x, 3'd3);
        step(1'b0, 1'b0, 0, 0);
        check("final_frame_cnt_s", frame_cnt_s, exp_frames);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
